mouse_spinner_accum: RTL and testbench

- Converts HPS mouse X motion, or digital left/right buttons, into the wrapping spinner angle that feeds the MCR1 game input port (Kick's `input_1[3:0]`).
- Mouse counts accumulate between frames. The angle is advanced once per frame on the rising edge of the vertical sync strobe, rate-limited, so the game sees gradual, bounded motion.
- Sits in the emu top level between hps_io (mouse/joystick) and the mcr1 core inputs.

---
 rtl/mouse_spinner_accum.sv | 106 ++++++++++
 tb/tb_mouse_spinner_accum.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_spinner_accum.sv
// Spinner angle generator for the MCR1 game input port.
// Mouse X counts (or left/right buttons) are accumulated between frames and
// turned into a bounded, wrapping angle step once per frame strobe rising edge.
module mouse_spinner_accum #(
    parameter int ANGLE_W  = 4,
    parameter int ACC_W    = 10,
    parameter int DIV_SH   = 2,
    parameter int MAX_STEP = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mouse_strobe,
    input  logic signed [8:0]  mouse_dx,
    input  logic               use_mouse,
    input  logic               btn_minus,
    input  logic               btn_plus,
    input  logic               fast,
    input  logic               strobe,
    output logic [ANGLE_W-1:0] spin_angle,
    output logic               moved,
    output logic               dir
);

    localparam int SUM_W = ACC_W + 2;
    localparam logic [ACC_W-1:0]        MAX_V   = ACC_W'(MAX_STEP);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;

    logic                    strobe_d;
    logic                    use_mouse_d;
    logic signed [ACC_W-1:0] pending;
    logic signed [ACC_W-1:0] pending_next;
    logic                    fire;
    logic                    mode_change;
    logic [ACC_W-1:0]        pend_abs;
    logic [ACC_W-1:0]        pend_q;
    logic [ACC_W-1:0]        mag;
    logic signed [ACC_W-1:0] mouse_step;
    logic signed [ACC_W-1:0] button_step;
    logic signed [ACC_W-1:0] step;
    logic signed [SUM_W-1:0] sum;

    assign fire        = strobe & ~strobe_d;
    assign mode_change = use_mouse ^ use_mouse_d;

    // Step selection and next accumulator value; the step is always derived
    // from the pending count before any same-cycle mouse delta is added.
    always_comb begin
        pend_abs    = pending[ACC_W-1] ? ACC_W'(-pending) : ACC_W'(pending);
        pend_q      = pend_abs >> DIV_SH;
        mag         = (pend_q > MAX_V) ? MAX_V : pend_q;
        mouse_step  = pending[ACC_W-1] ? -$signed(mag) : $signed(mag);

        button_step = '0;
        if (btn_plus && !btn_minus) begin
            button_step = fast ? ACC_W'(2) : ACC_W'(1);
        end else if (btn_minus && !btn_plus) begin
            button_step = fast ? ACC_W'(-2) : ACC_W'(-1);
        end

        // A mode switch discards motion for this frame.
        step = '0;
        if (fire && !mode_change) begin
            step = use_mouse ? mouse_step : button_step;
        end

        sum = SUM_W'(pending);
        if (fire && use_mouse && !mode_change) begin
            sum = sum - (SUM_W'(step) <<< DIV_SH);
        end
        if (use_mouse && mouse_strobe) begin
            sum = sum + SUM_W'(mouse_dx);
        end

        // Clamp symmetrically so the accumulator never wraps.
        if (sum > SAT_MAX) begin
            sum = SAT_MAX;
        end else if (sum < SAT_MIN) begin
            sum = SAT_MIN;
        end

        pending_next = mode_change ? '0 : sum[ACC_W-1:0];
    end

    // State registers: edge detect, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_d    <= 1'b0;
            use_mouse_d <= 1'b0;
            pending     <= '0;
            spin_angle  <= '0;
            moved       <= 1'b0;
            dir         <= 1'b0;
        end else begin
            strobe_d    <= strobe;
            use_mouse_d <= use_mouse;
            pending     <= pending_next;
            moved       <= (step != '0);
            if (step != '0) begin
                spin_angle <= spin_angle + step[ANGLE_W-1:0];
                dir        <= ~step[ACC_W-1];
            end
        end
    end

endmodule

// File: tb/tb_mouse_spinner_accum.sv
// Directed bench for mouse_spinner_accum: button stepping, mouse quantisation,
// rate limiting, saturation, simultaneous events, mode switch and reset.
module tb_mouse_spinner_accum;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              mouse_strobe = 1'b0;
    logic signed [8:0] mouse_dx = '0;
    logic              use_mouse = 1'b0;
    logic              btn_minus = 1'b0;
    logic              btn_plus = 1'b0;
    logic              fast = 1'b0;
    logic              strobe = 1'b0;
    logic [3:0]        spin_angle;
    logic              moved;
    logic              dir;

    int checks = 0;
    int errors = 0;
    int pulses;

    mouse_spinner_accum dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mouse_strobe (mouse_strobe),
        .mouse_dx     (mouse_dx),
        .use_mouse    (use_mouse),
        .btn_minus    (btn_minus),
        .btn_plus     (btn_plus),
        .fast         (fast),
        .strobe       (strobe),
        .spin_angle   (spin_angle),
        .moved        (moved),
        .dir          (dir)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mouse(input int dx);
        mouse_dx     = 9'(dx);
        mouse_strobe = 1'b1;
        tick();
        mouse_strobe = 1'b0;
    endtask

    // One frame: strobe rises, result is sampled one clk later, moved must
    // then fall while strobe is still held high.
    task automatic frame(input string tag, input int exp_angle, input int exp_moved);
        strobe = 1'b1;
        tick();
        $display("frame %s angle=%0d moved=%0d dir=%0d", tag, spin_angle, moved, dir);
        check_val({tag, " angle"}, int'(spin_angle), exp_angle);
        check_val({tag, " moved"}, int'(moved), exp_moved);
        tick();
        check_val({tag, " moved_drop"}, int'(moved), 0);
        strobe = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_val("rst angle", int'(spin_angle), 0);
        check_val("rst moved", int'(moved), 0);
        check_val("rst dir", int'(dir), 0);
        reset_n = 1'b1;
        tick();

        // Button mode, decrement with wrap
        btn_minus = 1'b1;
        frame("minus1", 15, 1);
        check_val("minus1 dir", int'(dir), 0);
        frame("minus2", 14, 1);
        frame("minus3", 13, 1);
        check_val("minus3 dir", int'(dir), 0);

        // Button mode, increment then fast increment with wrap
        btn_minus = 1'b0;
        btn_plus  = 1'b1;
        frame("plus1", 14, 1);
        check_val("plus1 dir", int'(dir), 1);
        fast = 1'b1;
        frame("fast1", 0, 1);
        frame("fast2", 2, 1);
        check_val("fast2 dir", int'(dir), 1);

        // Both buttons: no movement, dir holds
        btn_minus = 1'b1;
        frame("both", 2, 0);
        check_val("both dir", int'(dir), 1);

        // Strobe held high gives exactly one update
        btn_minus = 1'b0;
        fast      = 1'b0;
        strobe    = 1'b1;
        pulses    = 0;
        repeat (6) begin
            tick();
            if (moved) pulses++;
        end
        strobe = 1'b0;
        tick();
        $display("held strobe pulses=%0d angle=%0d", pulses, spin_angle);
        check_val("held pulses", pulses, 1);
        check_val("held angle", int'(spin_angle), 3);
        btn_plus = 1'b0;

        // Mouse quantisation and deadband
        use_mouse = 1'b1;
        tick();
        tick();
        mouse(3);
        mouse(2);
        check_val("q pending5", int'(dut.pending), 5);
        frame("q1", 4, 1);
        check_val("q1 pending", int'(dut.pending), 1);
        check_val("q1 dir", int'(dir), 1);
        frame("q2", 4, 0);
        mouse(-9);
        check_val("q pending-8", int'(dut.pending), -8);
        frame("q3", 2, 1);
        check_val("q3 dir", int'(dir), 0);
        check_val("q3 pending", int'(dut.pending), 0);

        // Saturation and rate limit: 4 x 255 clamps at 511, each frame +2
        repeat (4) mouse(255);
        check_val("sat pending", int'(dut.pending), 511);
        for (int i = 1; i <= 10; i++) begin
            frame($sformatf("sat%0d", i), (2 + 2 * i) % 16, 1);
        end
        check_val("sat angle", int'(spin_angle), 6);
        check_val("sat pending after", int'(dut.pending), 431);

        // Mode toggle clears pending
        use_mouse = 1'b0;
        tick();
        use_mouse = 1'b1;
        tick();
        check_val("toggle pending", int'(dut.pending), 0);

        // Simultaneous fire and mouse delta: step from old pending (8)
        mouse(8);
        check_val("sim pending8", int'(dut.pending), 8);
        strobe       = 1'b1;
        mouse_dx     = 9'sd4;
        mouse_strobe = 1'b1;
        tick();
        mouse_strobe = 1'b0;
        $display("simultaneous angle=%0d moved=%0d pending=%0d", spin_angle, moved, dut.pending);
        check_val("sim angle", int'(spin_angle), 8);
        check_val("sim moved", int'(moved), 1);
        check_val("sim pending", int'(dut.pending), 4);
        tick();
        strobe = 1'b0;
        tick();
        frame("after_sim", 9, 1);
        check_val("after_sim pending", int'(dut.pending), 0);

        // Mode switch 1 -> 0 -> 1 discards pending
        mouse(20);
        check_val("sw pending20", int'(dut.pending), 20);
        use_mouse = 1'b0;
        tick();
        use_mouse = 1'b1;
        tick();
        check_val("sw pending", int'(dut.pending), 0);
        frame("post_switch", 9, 0);

        // Fire in the same cycle as a mode change uses step 0
        mouse(20);
        btn_plus  = 1'b1;
        use_mouse = 1'b0;
        strobe    = 1'b1;
        tick();
        $display("mode change fire angle=%0d moved=%0d", spin_angle, moved);
        check_val("mc angle", int'(spin_angle), 9);
        check_val("mc moved", int'(moved), 0);
        check_val("mc pending", int'(dut.pending), 0);
        tick();
        strobe   = 1'b0;
        btn_plus = 1'b0;
        tick();

        // Asynchronous reset mid-frame
        use_mouse = 1'b1;
        tick();
        mouse(20);
        reset_n = 1'b0;
        #1;
        $display("async reset angle=%0d moved=%0d", spin_angle, moved);
        check_val("areset angle", int'(spin_angle), 0);
        check_val("areset moved", int'(moved), 0);
        check_val("areset pending", int'(dut.pending), 0);
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            frame($sformatf("idle%0d", i), 0, 0);
        end
        mouse(4);
        frame("first_after_reset", 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
